spectral_peak_finder: RTL



---
 rtl/spectral_peak_finder_pkg.sv | 19 +
 rtl/spectral_peak_finder_peak_tracker.sv | 91 +++++++++
 rtl/spectral_peak_finder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/spectral_peak_finder_pkg.sv
// Shared types and default sizing for the spectral front end (magnitude stage and peak finder).
package spectral_pkg;

  localparam int DEF_NUM_BINS  = 1024;
  localparam int DEF_MAG_WIDTH = 32;

  function automatic int bin_width(input int num_bins);
    return $clog2(num_bins);
  endfunction

  localparam int BIN_W = bin_width(DEF_NUM_BINS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_e;

endpackage

// File: rtl/spectral_peak_finder_peak_tracker.sv
// Running maximum over a frame's in-window bins; neighbour magnitudes are kept when PEAK_INTERP_EN is defined.
module peak_tracker #(
  parameter int BIN_W     = 10,
  parameter int MAG_WIDTH = 32,
  parameter int MIN_BIN   = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 clear_in,
  input  logic                 sample_in,
  input  logic                 window_in,
  input  logic [BIN_W-1:0]     bin_in,
  input  logic [MAG_WIDTH-1:0] mag_in,
  output logic [MAG_WIDTH-1:0] nxt_mag_out,
  output logic [BIN_W-1:0]     nxt_bin_out
`ifdef PEAK_INTERP_EN
  ,
  output logic [MAG_WIDTH-1:0] nxt_left_out,
  output logic [MAG_WIDTH-1:0] nxt_right_out
`endif
);

  logic [MAG_WIDTH-1:0] best_mag_q, best_mag_d, base_mag_s;
  logic [BIN_W-1:0]     best_bin_q, best_bin_d, base_bin_s;
  logic                 update_s;
`ifdef PEAK_INTERP_EN
  logic [MAG_WIDTH-1:0] prev_mag_q, prev_mag_d, prev_base_s;
  logic [MAG_WIDTH-1:0] left_q, left_d, right_q, right_d;
  logic                 pend_q, pend_d;
`endif

  // Clear folds into the compare so a frame-start sample is judged against an empty history.
  always_comb begin
    base_mag_s = clear_in ? {MAG_WIDTH{1'b0}} : best_mag_q;
    base_bin_s = clear_in ? BIN_W'(MIN_BIN) : best_bin_q;
    update_s   = sample_in && window_in && (mag_in > base_mag_s);
    best_mag_d = update_s ? mag_in : base_mag_s;
    best_bin_d = update_s ? bin_in : base_bin_s;
`ifdef PEAK_INTERP_EN
    prev_base_s = clear_in ? {MAG_WIDTH{1'b0}} : prev_mag_q;
    prev_mag_d  = sample_in ? mag_in : prev_mag_q;
    left_d      = left_q;
    right_d     = right_q;
    pend_d      = pend_q;
    if (update_s) begin
      left_d  = prev_base_s;
      right_d = {MAG_WIDTH{1'b0}};
      pend_d  = 1'b1;
    end else if (clear_in) begin
      left_d  = {MAG_WIDTH{1'b0}};
      right_d = {MAG_WIDTH{1'b0}};
      pend_d  = 1'b0;
    end else if (sample_in && pend_q) begin
      right_d = mag_in;
      pend_d  = 1'b0;
    end else begin
      pend_d = pend_q;
    end
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      best_mag_q <= {MAG_WIDTH{1'b0}};
      best_bin_q <= BIN_W'(MIN_BIN);
`ifdef PEAK_INTERP_EN
      prev_mag_q <= {MAG_WIDTH{1'b0}};
      left_q     <= {MAG_WIDTH{1'b0}};
      right_q    <= {MAG_WIDTH{1'b0}};
      pend_q     <= 1'b0;
`endif
    end else begin
      best_mag_q <= best_mag_d;
      best_bin_q <= best_bin_d;
`ifdef PEAK_INTERP_EN
      prev_mag_q <= prev_mag_d;
      left_q     <= left_d;
      right_q    <= right_d;
      pend_q     <= pend_d;
`endif
    end
  end

  assign nxt_mag_out = best_mag_d;
  assign nxt_bin_out = best_bin_d;
`ifdef PEAK_INTERP_EN
  assign nxt_left_out  = left_d;
  assign nxt_right_out = right_d;
`endif

endmodule

// File: rtl/spectral_peak_finder.sv
// Per-frame spectral peak finder: frame FSM, bin counter and registered report outputs.
// Optional PEAK_INTERP_EN adds peak_left_out/peak_right_out neighbour magnitudes.
module spectral_peak_finder
  import spectral_pkg::*;
#(
  parameter int NUM_BINS  = DEF_NUM_BINS,
  parameter int MAG_WIDTH = DEF_MAG_WIDTH,
  parameter int MIN_BIN   = 1,
  parameter int MAX_BIN   = 511
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [MAG_WIDTH-1:0]         mag_in,
  input  logic                         mag_valid_in,
  input  logic                         frame_start_in,
  input  logic [MAG_WIDTH-1:0]         threshold_in,
  output logic                         peak_valid_out,
  output logic [$clog2(NUM_BINS)-1:0]  peak_bin_out,
  output logic [MAG_WIDTH-1:0]         peak_mag_out,
  output logic                         peak_found_out,
  output logic                         frame_error_out
`ifdef PEAK_INTERP_EN
  ,
  output logic [MAG_WIDTH-1:0]         peak_left_out,
  output logic [MAG_WIDTH-1:0]         peak_right_out
`endif
);

  localparam int BW = bin_width(NUM_BINS);
  localparam logic [BW-1:0] LAST_BIN = BW'(NUM_BINS - 1);

  state_e               state_q, state_d;
  logic [BW-1:0]        cnt_q, cnt_d;
  logic [MAG_WIDTH-1:0] thr_q, thr_d;
  logic                 peak_valid_q, peak_valid_d;
  logic [BW-1:0]        peak_bin_q, peak_bin_d;
  logic [MAG_WIDTH-1:0] peak_mag_q, peak_mag_d;
  logic                 peak_found_q, peak_found_d;
  logic                 frame_error_q, frame_error_d;

  logic                 clear_s, sample_s, window_s;
  logic [BW-1:0]        bin_s;
  int                   bin_int_s;
  logic [MAG_WIDTH-1:0] nxt_mag_s;
  logic [BW-1:0]        nxt_bin_s;
`ifdef PEAK_INTERP_EN
  logic [MAG_WIDTH-1:0] nxt_left_s, nxt_right_s;
  logic [MAG_WIDTH-1:0] peak_left_q, peak_left_d, peak_right_q, peak_right_d;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    thr_d         = thr_q;
    peak_valid_d  = 1'b0;
    peak_bin_d    = peak_bin_q;
    peak_mag_d    = peak_mag_q;
    peak_found_d  = peak_found_q;
    frame_error_d = 1'b0;
    clear_s       = 1'b0;
    sample_s      = 1'b0;
    bin_s         = cnt_q;
`ifdef PEAK_INTERP_EN
    peak_left_d   = peak_left_q;
    peak_right_d  = peak_right_q;
`endif
    // A frame-start sample restarts from any state; inside SCAN it also flags the aborted frame.
    if (mag_valid_in && frame_start_in) begin
      thr_d         = threshold_in;
      cnt_d         = BW'(1);
      state_d       = SCAN;
      clear_s       = 1'b1;
      sample_s      = 1'b1;
      bin_s         = {BW{1'b0}};
      frame_error_d = (state_q == SCAN);
    end else begin
      case (state_q)
        SCAN: begin
          if (mag_valid_in) begin
            sample_s = 1'b1;
            if (cnt_q == LAST_BIN) begin
              state_d      = REPORT;
              cnt_d        = {BW{1'b0}};
              peak_valid_d = 1'b1;
              peak_bin_d   = nxt_bin_s;
              peak_mag_d   = nxt_mag_s;
              peak_found_d = (nxt_mag_s > thr_q);
`ifdef PEAK_INTERP_EN
              peak_left_d  = nxt_left_s;
              peak_right_d = nxt_right_s;
`endif
            end else begin
              cnt_d = cnt_q + BW'(1);
            end
          end else begin
            state_d = SCAN;
          end
        end
        IDLE, REPORT: state_d = IDLE;
        default:      state_d = IDLE;
      endcase
    end
    bin_int_s = int'(bin_s);
    window_s  = (bin_int_s >= MIN_BIN) && (bin_int_s <= MAX_BIN);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      cnt_q         <= {BW{1'b0}};
      thr_q         <= {MAG_WIDTH{1'b0}};
      peak_valid_q  <= 1'b0;
      peak_bin_q    <= {BW{1'b0}};
      peak_mag_q    <= {MAG_WIDTH{1'b0}};
      peak_found_q  <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef PEAK_INTERP_EN
      peak_left_q   <= {MAG_WIDTH{1'b0}};
      peak_right_q  <= {MAG_WIDTH{1'b0}};
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      thr_q         <= thr_d;
      peak_valid_q  <= peak_valid_d;
      peak_bin_q    <= peak_bin_d;
      peak_mag_q    <= peak_mag_d;
      peak_found_q  <= peak_found_d;
      frame_error_q <= frame_error_d;
`ifdef PEAK_INTERP_EN
      peak_left_q   <= peak_left_d;
      peak_right_q  <= peak_right_d;
`endif
    end
  end

  peak_tracker #(
    .BIN_W     (BW),
    .MAG_WIDTH (MAG_WIDTH),
    .MIN_BIN   (MIN_BIN)
  ) u_tracker (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .clear_in      (clear_s),
    .sample_in     (sample_s),
    .window_in     (window_s),
    .bin_in        (bin_s),
    .mag_in        (mag_in),
    .nxt_mag_out   (nxt_mag_s),
    .nxt_bin_out   (nxt_bin_s)
`ifdef PEAK_INTERP_EN
    ,
    .nxt_left_out  (nxt_left_s),
    .nxt_right_out (nxt_right_s)
`endif
  );

  assign peak_valid_out  = peak_valid_q;
  assign peak_bin_out    = peak_bin_q;
  assign peak_mag_out    = peak_mag_q;
  assign peak_found_out  = peak_found_q;
  assign frame_error_out = frame_error_q;
`ifdef PEAK_INTERP_EN
  assign peak_left_out   = peak_left_q;
  assign peak_right_out  = peak_right_q;
`endif

endmodule
